// File: rtl/corr_params.sv
// rtl/corr_params.sv - shared frame geometry and datapath widths for the correlation blocks
// Also provides the coordinate range check and the linear SRAM address mapping.
package corr_params;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int ADDR_W      = 20;
    localparam int PIX_W       = 10;
    localparam int COORD_W     = 13;
    localparam int SRAM_DATA_W = 16;
    // Wide enough to hold any Y*H_RES+X for COORD_W-bit coordinates before truncation.
    localparam int FULL_ADDR_W = 2 * COORD_W;

    function automatic logic coord_oob(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        return (x >= COORD_W'(H_RES)) || (y >= COORD_W'(V_RES));
    endfunction

    // Constant multiply by the frame width; the result wraps into the SRAM address space.
    function automatic logic [ADDR_W-1:0] linear_addr(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        return ADDR_W'(FULL_ADDR_W'(y) * FULL_ADDR_W'(H_RES) + FULL_ADDR_W'(x));
    endfunction

endpackage

// File: rtl/corr_pixel_server_if.sv
// rtl/corr_pixel_server_if.sv - request, response and SRAM signal bundle of the pixel server
// Ports (slave = pixel server view):
//   iReq_valid/oReq_ready/iX/iY      coordinate request handshake
//   oPix_valid/iPix_ready/oPix/oPix_oob  pixel response handshake
//   oSRAM_addr/oSRAM_rd/iSRAM_data   frame SRAM read port
interface corr_pixel_server_if;
    import corr_params::*;

    logic                   iReq_valid;
    logic                   oReq_ready;
    logic [COORD_W-1:0]     iX;
    logic [COORD_W-1:0]     iY;
    logic                   oPix_valid;
    logic                   iPix_ready;
    logic [PIX_W-1:0]       oPix;
    logic                   oPix_oob;
    logic [ADDR_W-1:0]      oSRAM_addr;
    logic                   oSRAM_rd;
    logic [SRAM_DATA_W-1:0] iSRAM_data;

    modport slave (
        input  iReq_valid, iX, iY, iPix_ready, iSRAM_data,
        output oReq_ready, oPix_valid, oPix, oPix_oob, oSRAM_addr, oSRAM_rd
    );

    modport master (
        output iReq_valid, iX, iY, iPix_ready, iSRAM_data,
        input  oReq_ready, oPix_valid, oPix, oPix_oob, oSRAM_addr, oSRAM_rd
    );

endinterface

// File: rtl/corr_pix_fifo.sv
// rtl/corr_pix_fifo.sv - show-ahead response FIFO holding {pixel, oob} entries
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_s_tvalid, i_s_tdata        push side (no ready: the producer is credit limited)
//   o_m_tvalid, o_m_tdata        head entry, zero while empty
//   i_m_tready                   pop the head entry
module corr_pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s_tvalid,
    input  logic [WIDTH-1:0] i_s_tdata,
    output logic             o_m_tvalid,
    output logic [WIDTH-1:0] o_m_tdata,
    input  logic             i_m_tready
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty differ when the indices match.
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = i_m_tready && !w_empty;
    // On a full FIFO a write is only safe when the head leaves in the same cycle.
    assign w_push  = i_s_tvalid && (!w_full || w_pop);

    assign o_m_tvalid = !w_empty;
    assign o_m_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_s_tdata;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_s_tvalid && w_full && !w_pop));

endmodule

// File: rtl/corr_pixel_server.sv
// rtl/corr_pixel_server.sv - coordinate-to-SRAM pixel read responder with credit-based ready
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   pix_if         slave side of corr_pixel_server_if (requests, responses, SRAM read port)
// Parameters: RD_LAT = SRAM read latency (1..4), DEPTH = response buffer depth (power of two).
module corr_pixel_server
    import corr_params::*;
#(
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    corr_pixel_server_if.slave pix_if
);
    localparam int CRED_W  = $clog2(DEPTH + 1);
    localparam int ENTRY_W = PIX_W + 1;

    logic                w_oob;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_ready;
    logic                w_accept;
    logic                w_rd_now;
    logic                w_pop;
    logic                w_fifo_v;
    logic [ENTRY_W-1:0]  w_fifo_entry;
    logic                w_unused_sram_hi;

    logic [CRED_W-1:0]   r_credits;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic                r_sram_rd;
    logic [RD_LAT:0]     r_tag_v;
    logic [RD_LAT:0]     r_tag_oob;
    logic                r_smp_v;
    logic [ENTRY_W-1:0]  r_smp_entry;

    assign w_oob    = coord_oob(pix_if.iX, pix_if.iY);
    assign w_addr   = linear_addr(pix_if.iX, pix_if.iY);
    assign w_ready  = (r_credits != '0) && iRST_N;
    assign w_accept = pix_if.iReq_valid && w_ready;
    assign w_rd_now = w_accept && !w_oob;
    assign w_pop    = w_fifo_v && pix_if.iPix_ready;

    // Only the low PIX_W bits of an SRAM word carry the pixel.
    assign w_unused_sram_hi = ^pix_if.iSRAM_data[SRAM_DATA_W-1:PIX_W];

    // Out-of-range requests leave the address bus untouched and issue no strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sram_addr <= '0;
            r_sram_rd   <= 1'b0;
        end else begin
            r_sram_rd <= w_rd_now;
            if (w_rd_now) begin
                r_sram_addr <= w_addr;
            end
        end
    end

    // Every accepted request, including out-of-range ones, walks the same tag
    // pipeline so responses leave in request order.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_tag_v   <= '0;
            r_tag_oob <= '0;
        end else begin
            r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_accept};
            r_tag_oob <= {r_tag_oob[RD_LAT-1:0], w_accept && w_oob};
        end
    end

    // SRAM data is captured on the edge the last tag stage lines up with it,
    // then written to the FIFO on the following edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_smp_v     <= 1'b0;
            r_smp_entry <= '0;
        end else begin
            r_smp_v <= r_tag_v[RD_LAT];
            if (r_tag_v[RD_LAT]) begin
                r_smp_entry <= r_tag_oob[RD_LAT] ? ENTRY_W'(1)
                                                 : {pix_if.iSRAM_data[PIX_W-1:0], 1'b0};
            end
        end
    end

    // Credits cover in-flight reads plus buffered responses, so the FIFO can
    // never be pushed while full.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_credits <= CRED_W'(DEPTH);
        end else if (w_accept && !w_pop) begin
            r_credits <= r_credits - CRED_W'(1);
        end else if (w_pop && !w_accept) begin
            r_credits <= r_credits + CRED_W'(1);
        end
    end

    corr_pix_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk      (iCLK),
        .i_rst_n    (iRST_N),
        .i_s_tvalid (r_smp_v),
        .i_s_tdata  (r_smp_entry),
        .o_m_tvalid (w_fifo_v),
        .o_m_tdata  (w_fifo_entry),
        .i_m_tready (pix_if.iPix_ready)
    );

    assign pix_if.oReq_ready = w_ready;
    assign pix_if.oPix_valid = w_fifo_v;
    assign pix_if.oPix       = w_fifo_entry[ENTRY_W-1:1];
    assign pix_if.oPix_oob   = w_fifo_entry[0];
    assign pix_if.oSRAM_addr = r_sram_addr;
    assign pix_if.oSRAM_rd   = r_sram_rd;

endmodule

// File: tb/tb_corr_pixel_server.sv
// tb/tb_corr_pixel_server.sv - scoreboard bench for corr_pixel_server with an SRAM model
module tb_corr_pixel_server;
    import corr_params::*;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;
    localparam int FW     = 640;
    localparam int FH     = 480;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;

    corr_pixel_server_if bus();

    corr_pixel_server #(.RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .pix_if (bus)
    );

    always #10 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PIX_W:0] exp_q[$];
    int addr_q[$];
    int outstanding = 0;
    int accepts = 0;
    int pops = 0;
    int strobes = 0;
    logic stall_prev = 1'b0;
    logic [PIX_W:0] stall_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // SRAM contents: low 10 bits derived from the address, junk in the top bits.
    function automatic logic [PIX_W-1:0] pix_of(input int a);
        return PIX_W'((a & 1023) ^ ((a >> 10) & 1023) ^ 'h3AF);
    endfunction

    function automatic logic [PIX_W:0] expect_resp(input int x, input int y);
        if (x >= FW || y >= FH) return {{PIX_W{1'b0}}, 1'b1};
        return {pix_of((y * FW + x) % (1 << 20)), 1'b0};
    endfunction

    // SRAM: latches {rd, addr} at the end of the address cycle, data appears RD_LAT-1 edges later.
    logic [ADDR_W:0] sram_pipe [RD_LAT];
    always @(posedge iCLK) begin
        sram_pipe[0] <= {bus.oSRAM_rd, bus.oSRAM_addr};
        for (int i = 1; i < RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign bus.iSRAM_data = sram_pipe[RD_LAT-1][ADDR_W]
                          ? {6'h2A, pix_of(int'(sram_pipe[RD_LAT-1][ADDR_W-1:0]))}
                          : 16'hDEAD;

    // Monitor: samples on the falling edge, checks strobes, ready, responses, then records accepts.
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            int acc;
            int pop;
            acc = 0;
            pop = 0;
            if (bus.oSRAM_rd) begin
                strobes++;
                chk("strobe_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("sram_addr", bus.oSRAM_addr, addr_q.pop_front());
            end
            chk("req_ready", bus.oReq_ready, outstanding < DEPTH);
            if (stall_prev && bus.oPix_valid)
                chk("showahead_stable", {bus.oPix, bus.oPix_oob}, stall_val);
            stall_prev = bus.oPix_valid && !bus.iPix_ready;
            stall_val  = {bus.oPix, bus.oPix_oob};
            if (bus.oPix_valid && bus.iPix_ready) begin
                pop = 1;
                pops++;
                chk("resp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("resp_pixel_oob", {bus.oPix, bus.oPix_oob}, exp_q.pop_front());
            end
            if (bus.iReq_valid && bus.oReq_ready) begin
                int x;
                int y;
                acc = 1;
                accepts++;
                x = int'(bus.iX);
                y = int'(bus.iY);
                exp_q.push_back(expect_resp(x, y));
                if (x < FW && y < FH) addr_q.push_back(y * FW + x);
            end
            outstanding = outstanding + acc - pop;
        end
    end

    task automatic send(input int x, input int y);
        bit acc;
        int guard;
        bus.iReq_valid = 1'b1;
        bus.iX = 13'(x);
        bus.iY = 13'(y);
        acc = 0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge iCLK);
            acc = bus.oReq_ready;
            @(posedge iCLK);
            #1;
            guard++;
        end
        chk("send_accepted", acc, 1);
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && guard < 1000) begin
            @(negedge iCLK);
            guard++;
        end
        chk(name, exp_q.size() + addr_q.size(), 0);
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int s0;
        int p0;
        int n;
        int cyc;
        bit acc;

        bus.iReq_valid = 1'b0;
        bus.iX = '0;
        bus.iY = '0;
        bus.iPix_ready = 1'b0;
        #1;
        chk("rst_req_ready", bus.oReq_ready, 0);
        chk("rst_pix_valid", bus.oPix_valid, 0);
        chk("rst_pix", bus.oPix, 0);
        chk("rst_pix_oob", bus.oPix_oob, 0);
        chk("rst_sram_rd", bus.oSRAM_rd, 0);
        chk("rst_sram_addr", bus.oSRAM_addr, 0);
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        @(posedge iCLK);
        #1;

        // Single read with exact latency.
        bus.iPix_ready = 1'b1;
        bus.iReq_valid = 1'b1;
        bus.iX = 13'd5;
        bus.iY = 13'd2;
        @(negedge iCLK);
        chk("single_ready", bus.oReq_ready, 1);
        @(posedge iCLK);
        #1 bus.iReq_valid = 1'b0;
        @(negedge iCLK);
        chk("single_rd", bus.oSRAM_rd, 1);
        chk("single_addr", bus.oSRAM_addr, 1285);
        @(negedge iCLK);
        chk("single_rd_one_cycle", bus.oSRAM_rd, 0);
        @(negedge iCLK);
        @(negedge iCLK);
        chk("single_not_early", bus.oPix_valid, 0);
        @(negedge iCLK);
        chk("single_valid", bus.oPix_valid, 1);
        chk("single_pix", bus.oPix, 'h2AB);
        chk("single_oob", bus.oPix_oob, 0);
        wait_drain("single_drain");

        // Corner pixel and out-of-range requests.
        s0 = strobes;
        send(639, 479);
        send(640, 0);
        send(0, 480);
        bus.iReq_valid = 1'b0;
        wait_drain("corner_drain");
        chk("corner_strobes", strobes - s0, 1);

        // Backpressure: six back-to-back offers with the consumer stalled.
        bus.iPix_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 6; i++) begin
            bus.iReq_valid = 1'b1;
            bus.iX = 13'(10 + i);
            bus.iY = 13'd20;
            @(posedge iCLK);
            #1;
        end
        bus.iReq_valid = 1'b0;
        chk("bp_accepted", accepts - a0, 4);
        repeat (6) @(posedge iCLK);
        #1;
        @(negedge iCLK);
        chk("bp_ready_low", bus.oReq_ready, 0);
        chk("bp_valid_held", bus.oPix_valid, 1);
        @(posedge iCLK);
        #1;

        // Pop one, then pop and accept in the same cycle.
        bus.iPix_ready = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iReq_valid = 1'b1;
        bus.iX = 13'd100;
        bus.iY = 13'd100;
        @(negedge iCLK);
        chk("simul_ready", bus.oReq_ready, 1);
        @(posedge iCLK);
        #1;
        bus.iReq_valid = 1'b0;
        bus.iPix_ready = 1'b0;
        @(negedge iCLK);
        chk("simul_credit_hold", bus.oReq_ready, 1);
        @(posedge iCLK);
        #1;
        bus.iPix_ready = 1'b1;
        wait_drain("bp_drain");

        // Streaming sequential coordinates across a row boundary.
        for (int i = 0; i < 100; i++) begin
            send((1200 + i) % FW, (1200 + i) / FW);
        end
        bus.iReq_valid = 1'b0;
        wait_drain("stream_drain");

        // Reset with three reads outstanding.
        send(1, 1);
        send(2, 1);
        send(3, 1);
        bus.iReq_valid = 1'b0;
        iRST_N = 1'b0;
        #1;
        chk("mrst_req_ready", bus.oReq_ready, 0);
        chk("mrst_pix_valid", bus.oPix_valid, 0);
        chk("mrst_pix", bus.oPix, 0);
        chk("mrst_pix_oob", bus.oPix_oob, 0);
        chk("mrst_sram_rd", bus.oSRAM_rd, 0);
        chk("mrst_sram_addr", bus.oSRAM_addr, 0);
        p0 = pops;
        repeat (2) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        repeat (12) @(posedge iCLK);
        #1;
        chk("mrst_no_stale", pops - p0, 0);
        @(negedge iCLK);
        chk("mrst_ready_back", bus.oReq_ready, 1);
        @(posedge iCLK);
        #1;

        // Random requests (some out of range) with random consumer stalls.
        n = 0;
        cyc = 0;
        while (n < 200 && cyc < 5000) begin
            if (!bus.iReq_valid && $urandom_range(0, 3) != 0) begin
                bus.iReq_valid = 1'b1;
                bus.iX = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 700));
                bus.iY = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 520));
            end
            bus.iPix_ready = ($urandom_range(0, 3) != 0);
            @(negedge iCLK);
            acc = bus.iReq_valid && bus.oReq_ready;
            @(posedge iCLK);
            #1;
            cyc++;
            if (acc) begin
                n++;
                bus.iReq_valid = 1'b0;
            end
        end
        chk("rand_count", n, 200);
        bus.iReq_valid = 1'b0;
        bus.iPix_ready = 1'b1;
        wait_drain("rand_drain");

        chk("final_outstanding", outstanding, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
